// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: constants and loader state shared by the MIPS instruction/data memory models
package mips_mem_pkg;
  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
  localparam logic [31:0] NOP_WORD     = 32'h0;
  typedef enum logic [1:0] {LD_EMPTY, LD_LOADING, LD_RUN} loader_state_t;
endpackage

// File: rtl/instr_memory_loader_if.sv
// instr_memory_loader_if: serial program-load port, CPU fetch bus and loader status
interface instr_memory_loader_if #(parameter int DEPTH_WORDS = 256);
  logic                         load_valid;
  logic                         load_ready;
  logic [31:0]                  load_data;
  logic                         load_last;
  logic                         cpu_reset;
  logic [31:0]                  instr_address;
  logic [31:0]                  instr_readdata;
  logic                         loaded;
  logic                         halted;
  logic                         fault;
  logic [$clog2(DEPTH_WORDS):0] word_count;
  modport master (
    output load_valid, load_data, load_last, instr_address,
    input  load_ready, cpu_reset, instr_readdata, loaded, halted, fault, word_count
  );
  modport slave (
    input  load_valid, load_data, load_last, instr_address,
    output load_ready, cpu_reset, instr_readdata, loaded, halted, fault, word_count
  );
endinterface

// File: rtl/instr_ram.sv
// instr_ram: word RAM with one synchronous write port and one asynchronous read port
module instr_ram #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);
  logic [31:0] r_mem [DEPTH_WORDS];
  // program words land in RAM one beat per accepted load
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/instr_memory_loader.sv
// instr_memory_loader: serially loaded instruction ROM that holds the CPU in reset until the program is resident
module instr_memory_loader
  import mips_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = RESET_VECTOR,
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] HALT_ADDR   = 32'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_enable,
  instr_memory_loader_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = AW + 1;
  loader_state_t r_state;
  logic [CW-1:0] r_wptr;
  logic          r_load_ready, r_cpu_reset, r_loaded, r_halted, r_fault;
  loader_state_t w_next;
  logic          w_run, w_beat, w_done, w_aligned, w_in_range, w_hit, w_is_halt;
  logic [29:0]   w_idx;
  logic [31:0]   w_rdata;
  assign w_run      = r_state == LD_RUN;
  assign w_beat     = r_load_ready & bus.load_valid & ~w_run;
  // the beat into the top slot ends the load regardless of load_last, so wptr never wraps
  assign w_done     = bus.load_last | (r_wptr == CW'(DEPTH_WORDS - 1));
  assign w_next     = w_beat ? (w_done ? LD_RUN : LD_LOADING) : r_state;
  // word index relative to the reset vector; BASE_ADDR is word aligned so the low bits drop out
  assign w_idx      = bus.instr_address[31:2] - BASE_ADDR[31:2];
  assign w_aligned  = bus.instr_address[1:0] == 2'b00;
  assign w_in_range = w_idx < 30'(r_wptr);
  assign w_hit      = w_run & w_aligned & w_in_range;
  assign w_is_halt  = bus.instr_address == HALT_ADDR;
  instr_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk     (clk),
    .i_we    (clk_enable & w_beat),
    .i_waddr (r_wptr[AW-1:0]),
    .i_wdata (bus.load_data),
    .i_raddr (w_idx[AW-1:0]),
    .o_rdata (w_rdata)
  );
  // loader FSM, write pointer and sticky fetch flags; all frozen while clk_enable is low
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state      <= LD_EMPTY;
      r_wptr       <= '0;
      r_load_ready <= 1'b0;
      r_cpu_reset  <= 1'b1;
      r_loaded     <= 1'b0;
      r_halted     <= 1'b0;
      r_fault      <= 1'b0;
    end else if (clk_enable) begin
      r_state      <= w_next;
      if (w_beat) r_wptr <= r_wptr + CW'(1);
      r_load_ready <= w_next != LD_RUN;
      r_cpu_reset  <= w_next != LD_RUN;
      r_loaded     <= w_next == LD_RUN;
      if (w_run & w_is_halt) r_halted <= 1'b1;
      if (w_run & ~w_is_halt & ~(w_aligned & w_in_range)) r_fault <= 1'b1;
    end
  assign bus.load_ready     = r_load_ready;
  assign bus.cpu_reset      = r_cpu_reset;
  assign bus.loaded         = r_loaded;
  assign bus.halted         = r_halted;
  assign bus.fault          = r_fault;
  assign bus.word_count     = r_wptr;
  assign bus.instr_readdata = w_hit ? w_rdata : NOP_WORD;
endmodule
